// File: rtl/cpu_do_demux.sv
// cpu_do_demux: Z80 I/O write decoder. Latches OUT data into LED/IOBYTE
// registers, strobes streaming devices, and stretches /WAIT while SPI is busy.
// Ports:
//   pll0_250MHz, reset          clock, synchronous active-high reset
//   cpuAdr, cpuDataOut          Z80 address low byte and data-out (async)
//   z80_iorq_n/wr_n/m1_n        Z80 control strobes, active-low (async)
//   sdSpiBusy, rtcSpiBusy       SPI engine busy flags (sync)
//   ledOut, iobyteOut           on-chip output registers
//   wrData                      byte latched for strobed devices
//   usbTxStb, sdWrStb, rtcWrStb one-clock write strobes
//   z80Wait_n                   Z80 /WAIT, active-low
module cpu_do_demux #(
    parameter logic [7:0] LED_PORT     = 8'hFF,
    parameter logic [7:0] IOBYTE_PORT  = 8'hEF,
    parameter logic [7:0] USBTX_PORT   = 8'h01,
    parameter logic [7:0] SDDATA_PORT  = 8'h30,
    parameter logic [7:0] RTCDATA_PORT = 8'h68,
    parameter logic [7:0] IOBYTE_RST   = 8'h00
) (
    input  logic       pll0_250MHz,
    input  logic       reset,
    input  logic [7:0] cpuAdr,
    input  logic [7:0] cpuDataOut,
    input  logic       z80_iorq_n,
    input  logic       z80_wr_n,
    input  logic       z80_m1_n,
    input  logic       sdSpiBusy,
    input  logic       rtcSpiBusy,
    output logic [7:0] ledOut,
    output logic [7:0] iobyteOut,
    output logic [7:0] wrData,
    output logic       usbTxStb,
    output logic       sdWrStb,
    output logic       rtcWrStb,
    output logic       z80Wait_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_WAITSPI, S_STROBE, S_HOLD
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] iorq_q, wr_q, m1_q;
    logic       ioWr, ioWr_q, ioWrPrev_q, evt;
    logic [7:0] adr_q, adr_d;
    logic [7:0] led_q, led_d;
    logic [7:0] iob_q, iob_d;
    logic [7:0] wrd_q, wrd_d;
    logic       usb_q, usb_d, sd_q, sd_d, rtc_q, rtc_d;
    logic       wait_q, wait_d;
    logic       isLed, isIob, isUsb, isSd, isRtc, selBusy;

    // Decode against the cycle's settled sync outputs; M1 high excludes INTA.
    assign ioWr = ~iorq_q[1] & ~wr_q[1] & m1_q[1];
    assign evt  = ioWr_q & ~ioWrPrev_q;

    // Priority chain keeps a single target even if two port params collide.
    assign isLed = (adr_q == LED_PORT);
    assign isIob = ~isLed & (adr_q == IOBYTE_PORT);
    assign isUsb = ~isLed & ~isIob & (adr_q == USBTX_PORT);
    assign isSd  = ~isLed & ~isIob & ~isUsb & (adr_q == SDDATA_PORT);
    assign isRtc = ~isLed & ~isIob & ~isUsb & ~isSd
                 & (adr_q == RTCDATA_PORT);
    assign selBusy = (isSd & sdSpiBusy) | (isRtc & rtcSpiBusy);

    always_ff @(posedge pll0_250MHz) begin
        if (reset) begin
            iorq_q     <= 2'b11;
            wr_q       <= 2'b11;
            m1_q       <= 2'b11;
            ioWr_q     <= 1'b0;
            ioWrPrev_q <= 1'b0;
            state_q    <= S_IDLE;
            adr_q      <= 8'h00;
            led_q      <= 8'h00;
            iob_q      <= IOBYTE_RST;
            wrd_q      <= 8'h00;
            usb_q      <= 1'b0;
            sd_q       <= 1'b0;
            rtc_q      <= 1'b0;
            wait_q     <= 1'b1;
        end else begin
            iorq_q     <= {iorq_q[0], z80_iorq_n};
            wr_q       <= {wr_q[0], z80_wr_n};
            m1_q       <= {m1_q[0], z80_m1_n};
            ioWr_q     <= ioWr;
            ioWrPrev_q <= ioWr_q;
            state_q    <= state_d;
            adr_q      <= adr_d;
            led_q      <= led_d;
            iob_q      <= iob_d;
            wrd_q      <= wrd_d;
            usb_q      <= usb_d;
            sd_q       <= sd_d;
            rtc_q      <= rtc_d;
            wait_q     <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        led_d   = led_q;
        iob_d   = iob_q;
        wrd_d   = wrd_q;
        usb_d   = 1'b0;
        sd_d    = 1'b0;
        rtc_d   = 1'b0;
        wait_d  = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (evt) begin
                    adr_d   = cpuAdr;
                    wrd_d   = cpuDataOut;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    isLed: begin
                        led_d   = wrd_q;
                        state_d = S_HOLD;
                    end
                    isIob: begin
                        iob_d   = wrd_q;
                        state_d = S_HOLD;
                    end
                    isUsb:         state_d = S_STROBE;
                    isSd || isRtc: state_d = selBusy ? S_WAITSPI : S_STROBE;
                    default:       state_d = S_HOLD;
                endcase
            end
            S_WAITSPI: if (!selBusy) state_d = S_STROBE;
            S_STROBE:  state_d = S_HOLD;
            S_HOLD:    if (!ioWr_q) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // Outputs are registered from the next state so they change cleanly
        // on the transition edge.
        if (state_d == S_WAITSPI) wait_d = 1'b0;
        if (state_d == S_STROBE) begin
            usb_d = isUsb;
            sd_d  = isSd;
            rtc_d = isRtc;
        end
    end

    assign ledOut    = led_q;
    assign iobyteOut = iob_q;
    assign wrData    = wrd_q;
    assign usbTxStb  = usb_q;
    assign sdWrStb   = sd_q;
    assign rtcWrStb  = rtc_q;
    assign z80Wait_n = wait_q;

endmodule

// File: tb/tb_cpu_do_demux.sv
// tb_cpu_do_demux: directed-vector bench for cpu_do_demux.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_cpu_do_demux;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cpuAdr, cpuDataOut;
    logic       iorq_n, wr_n, m1_n;
    logic       sdBusy, rtcBusy;
    logic [7:0] ledOut, iobyteOut, wrData;
    logic       usbTxStb, sdWrStb, rtcWrStb, z80Wait_n;

    int checks = 0;
    int errors = 0;
    int usbCnt, sdCnt, rtcCnt, waitLow, multiStb;

    cpu_do_demux dut (
        .pll0_250MHz(clk),
        .reset(reset),
        .cpuAdr(cpuAdr),
        .cpuDataOut(cpuDataOut),
        .z80_iorq_n(iorq_n),
        .z80_wr_n(wr_n),
        .z80_m1_n(m1_n),
        .sdSpiBusy(sdBusy),
        .rtcSpiBusy(rtcBusy),
        .ledOut(ledOut),
        .iobyteOut(iobyteOut),
        .wrData(wrData),
        .usbTxStb(usbTxStb),
        .sdWrStb(sdWrStb),
        .rtcWrStb(rtcWrStb),
        .z80Wait_n(z80Wait_n)
    );

    always #2 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        usbCnt  += int'(usbTxStb);
        sdCnt   += int'(sdWrStb);
        rtcCnt  += int'(rtcWrStb);
        waitLow += int'(!z80Wait_n);
        if (int'(usbTxStb) + int'(sdWrStb) + int'(rtcWrStb) > 1)
            multiStb++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr();
        usbCnt = 0; sdCnt = 0; rtcCnt = 0; waitLow = 0; multiStb = 0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic out_start(input logic [7:0] a, input logic [7:0] d);
        cpuAdr = a; cpuDataOut = d; iorq_n = 1'b0; wr_n = 1'b0;
    endtask

    task automatic bus_idle();
        iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    endtask

    initial begin
        reset = 1'b1; cpuAdr = 8'h00; cpuDataOut = 8'h00;
        sdBusy = 1'b0; rtcBusy = 1'b0;
        bus_idle();
        clr();
        ticks(3);
        chk("rst_led", ledOut, 8'h00);
        chk("rst_iob", iobyteOut, 8'h00);
        chk("rst_wrd", wrData, 8'h00);
        chk("rst_wait", z80Wait_n, 1);
        chk("rst_stb", {usbTxStb, sdWrStb, rtcWrStb}, 0);
        reset = 1'b0;
        ticks(2);

        // OUT (FFh),55h: LED updates at edge 5
        clr();
        out_start(8'hFF, 8'h55);
        ticks(4);
        chk("led_e4", ledOut, 8'h00);
        tick();
        chk("led_e5", ledOut, 8'h55);
        ticks(10);
        bus_idle();
        ticks(6);
        chk("led_stb", usbCnt + sdCnt + rtcCnt, 0);
        chk("led_wait", waitLow, 0);
        chk("led_iob", iobyteOut, 8'h00);

        // OUT (01h),41h held 200 clocks
        clr();
        out_start(8'h01, 8'h41);
        ticks(4);
        chk("usb_e4", usbTxStb, 0);
        tick();
        chk("usb_e5", usbTxStb, 1);
        chk("usb_wrd", wrData, 8'h41);
        tick();
        chk("usb_e6", usbTxStb, 0);
        ticks(194);
        bus_idle();
        ticks(6);
        chk("usb_cnt", usbCnt, 1);
        chk("usb_oth", sdCnt + rtcCnt, 0);
        chk("usb_wait", waitLow, 0);

        // OUT (30h),A5h with SD busy for 50 clocks
        clr();
        sdBusy = 1'b1;
        out_start(8'h30, 8'hA5);
        ticks(4);
        chk("sd_w_e4", z80Wait_n, 1);
        tick();
        chk("sd_w_e5", z80Wait_n, 0);
        ticks(45);
        chk("sd_w_hold", waitLow, 46);
        chk("sd_nostb", sdCnt, 0);
        sdBusy = 1'b0;
        tick();
        chk("sd_stb", sdWrStb, 1);
        chk("sd_w_rel", z80Wait_n, 1);
        chk("sd_wrd", wrData, 8'hA5);
        tick();
        chk("sd_stb_off", sdWrStb, 0);
        bus_idle();
        ticks(6);
        chk("sd_cnt", sdCnt, 1);
        chk("sd_oth", usbCnt + rtcCnt, 0);

        // interrupt acknowledge to FFh must be ignored
        clr();
        m1_n = 1'b0;
        out_start(8'hFF, 8'hAA);
        ticks(12);
        bus_idle();
        ticks(6);
        chk("inta_led", ledOut, 8'h55);
        chk("inta_stb", usbCnt + sdCnt + rtcCnt, 0);
        chk("inta_wrd", wrData, 8'hA5);

        // reset while waiting on RTC
        clr();
        rtcBusy = 1'b1;
        out_start(8'h68, 8'h77);
        ticks(6);
        chk("rtc_w", z80Wait_n, 0);
        reset = 1'b1;
        bus_idle();
        tick();
        chk("rtc_rst_w", z80Wait_n, 1);
        chk("rtc_rst_led", ledOut, 8'h00);
        chk("rtc_rst_iob", iobyteOut, 8'h00);
        chk("rtc_rst_wrd", wrData, 8'h00);
        ticks(2);
        reset = 1'b0;
        rtcBusy = 1'b0;
        ticks(10);
        chk("rtc_cnt", rtcCnt, 0);
        chk("rtc_oth", usbCnt + sdCnt, 0);

        // back-to-back OUTs with 2 idle clocks between
        clr();
        out_start(8'hEF, 8'h03);
        ticks(8);
        chk("b2b_iob", iobyteOut, 8'h03);
        bus_idle();
        ticks(2);
        out_start(8'hFF, 8'h0F);
        ticks(12);
        bus_idle();
        ticks(6);
        chk("b2b_led", ledOut, 8'h0F);
        chk("b2b_iob2", iobyteOut, 8'h03);
        chk("b2b_stb", usbCnt + sdCnt + rtcCnt, 0);
        chk("onehot", multiStb, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_do_demux.md
# cpu_do_demux

Z80 output-side write decoder for the T35 SBC FPGA core. It detects Z80 I/O write cycles and latches the Z80 data-out byte into on-chip output registers (LED, IOBYTE). It issues one-clock write strobes to streaming devices (USB TX, SD and RTC SPI data). It inserts Z80 wait states while an addressed SPI engine is busy. It is the write-direction counterpart of the CPU data-in multiplexer and runs in the `pll0_250MHz` domain.

## Interface

Parameters:
- `LED_PORT`, 8'hFF: I/O address of LED output register.
- `IOBYTE_PORT`, 8'hEF: I/O address of IOBYTE register.
- `USBTX_PORT`, 8'h01: I/O address of USB transmit data.
- `SDDATA_PORT`, 8'h30: I/O address of SD SPI data.
- `RTCDATA_PORT`, 8'h68: I/O address of RTC SPI data.
- `IOBYTE_RST`, 8'h00: reset value of `iobyteOut`.

Ports:
- `pll0_250MHz`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpuAdr`  in  8  Z80 A[7:0], asynchronous to clock.
- `cpuDataOut`  in  8  Z80 data-out bus, asynchronous.
- `z80_iorq_n`, `z80_wr_n`, `z80_m1_n`  in  1 each  Z80 control, active-low, asynchronous.
- `sdSpiBusy`, `rtcSpiBusy`  in  1 each  SPI engine busy, synchronous.
- `ledOut`  out  8  LED register.
- `iobyteOut`  out  8  IOBYTE register.
- `wrData`  out  8  latched data byte for strobed devices.
- `usbTxStb`, `sdWrStb`, `rtcWrStb`  out  1 each  one-clock write strobes.
- `z80Wait_n`  out  1  to Z80 /WAIT, active-low.

## Operation

- `z80_iorq_n`, `z80_wr_n` and `z80_m1_n` each pass through a 2-flop synchronizer.
- `ioWr` = synced iorq low AND synced wr low AND synced m1 high. M1-qualified interrupt-acknowledge cycles are ignored.
- An event occurs on the clock where `ioWr` is 1 and its previous-cycle value is 0.
- On an event, `cpuAdr` and `cpuDataOut` are sampled into `adrLat`/`wrData`. They are stable for the whole Z80 write.
- FSM states:
  - IDLE: on event, go to DECODE.
  - DECODE:
    - `adrLat` is LED_PORT or IOBYTE_PORT: write the register; go to HOLD.
    - `adrLat` is USBTX_PORT: go to STROBE.
    - `adrLat` is SDDATA_PORT: if `sdSpiBusy`=1, go to WAITSPI, else go to STROBE.
    - `adrLat` is RTCDATA_PORT: same rule using `rtcSpiBusy`.
    - Any other address: go to HOLD with no action; S-100 I/O boards handle it.
  - WAITSPI: `z80Wait_n`=0; when the selected busy flag is 0, go to STROBE.
  - STROBE: assert exactly one matching strobe for one clock; `z80Wait_n`=1; go to HOLD.
  - HOLD: stay until `ioWr`=0, then go to IDLE. Prevents double strobes within one Z80 cycle.
- At most one strobe is high in any clock. Strobes are never high in the same clock as each other.
- `wrData` holds its value until the next event.

## Timing

- Reset values: `ledOut`=8'h00, `iobyteOut`=IOBYTE_RST, `wrData`=8'h00, all strobes 0, `z80Wait_n`=1, FSM=IDLE, synchronizer flops=1 (inactive).
- A reset mid-operation (including in WAITSPI) forces these values on the next edge. Wait is released immediately and no strobe is issued.
- Latency is counted from the first edge where the raw iorq and wr are low:
  - Event detected at edge 3 (2 synchronizer stages plus edge register).
  - DECODE at edge 4.
  - Register update or strobe at edge 5.
- The Z80 write cycle is at least 2 Z80 T-states (500 ns or more), so this is well inside the cycle.
- In WAITSPI, `z80Wait_n` goes low at edge 5 and stays low until busy is observed 0. The strobe follows one clock after busy drops.
- If busy is already 0 in DECODE, no wait is generated.
- If `ioWr` deasserts while in WAITSPI (a protocol violation), the FSM still completes the strobe, then goes to HOLD and falls to IDLE.
- A second event cannot occur until HOLD has seen `ioWr`=0.
- Back-to-back Z80 OUTs are separated by at least one `ioWr` low clock. Both are decoded.

## Test plan

- Reset, then OUT (FFh),55h → `ledOut`=8'h55 at edge 5 after iorq/wr low. No strobes fire. `z80Wait_n` stays 1. `iobyteOut`=IOBYTE_RST.
- OUT (01h),41h held for 200 clocks → `usbTxStb` high for exactly 1 clock. `wrData`=8'h41. No second strobe.
- OUT (30h),A5h with `sdSpiBusy`=1 for 50 clocks → `z80Wait_n` low from edge 5 until busy falls. `sdWrStb` pulses 1 clock after busy falls, with `wrData`=8'hA5.
- Cycle with iorq/wr/m1 all low (interrupt acknowledge) to address FFh → `ledOut` is unchanged and no strobes fire.
- Reset asserted while in WAITSPI for RTC port 68h → `z80Wait_n`=1 next edge, `rtcWrStb` never pulses, and all outputs return to reset values.
- Two OUTs, (EFh),03h then (FFh),0Fh, separated by 2 idle clocks → `iobyteOut`=8'h03 and `ledOut`=8'h0F. Each register is written once.
